// File: rtl/cms_axis_downsizer_if.sv
// AXI-Stream bundle shared by the wide item input and the narrow beat output.
interface cms_axis_downsizer_if #(
  parameter int W = 64
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cms_axis_downsizer.sv
// Serialises one wide trace item into LSB-first OUT_WIDTH beats, trimmed to a
// per-item beat count; one item held at a time, zero-bubble reload on the last beat.
module cms_axis_downsizer #(
  parameter int  IN_WIDTH  = 1024,
  parameter int  OUT_WIDTH = 64,
  parameter int  CNT_WIDTH = 32,
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int BW        = $clog2(RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cms_axis_downsizer_if.slave  s_axis,
  cms_axis_downsizer_if.master m_axis,
  input  logic [BW-1:0]        beats_per_item,
  output logic [CNT_WIDTH-1:0] items_sent,
  output logic                 busy
);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
    $error("cms_axis_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [IN_WIDTH-1:0]  r_data;
  logic                 r_last;
  logic [BW-1:0]        r_nbeats;
  logic [BW-1:0]        r_k;
  logic [CNT_WIDTH-1:0] r_items;

  logic [OUT_WIDTH-1:0] w_words [RATIO];
  logic [BW-1:0]        w_nbeats_in;
  logic                 w_last_beat;
  logic                 w_m_hs;
  logic                 w_s_ready;
  logic                 w_accept;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_words
    assign w_words[gi] = r_data[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  assign w_last_beat = (r_k == r_nbeats - BW'(1));
  assign w_m_hs      = (r_state == SEND) && m_axis.tready;
  // Ready depends combinationally on downstream ready so a new item lands on the final-beat cycle.
  assign w_s_ready   = (r_state == IDLE) || (w_m_hs && w_last_beat);
  assign w_accept    = s_axis.tvalid && w_s_ready;
  assign w_nbeats_in = (beats_per_item == '0 || beats_per_item > BW'(RATIO)) ?
                       BW'(RATIO) : beats_per_item;

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = (r_state == SEND);
  assign m_axis.tdata  = w_words[r_k[BW-2:0]];
  assign m_axis.tlast  = (r_state == SEND) && r_last && w_last_beat;
  assign items_sent    = r_items;
  assign busy          = (r_state == SEND);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = SEND;
      SEND: if (w_m_hs && w_last_beat) w_state_next = w_accept ? SEND : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_last   <= 1'b0;
      r_nbeats <= '0;
      r_k      <= '0;
      r_items  <= '0;
    end else begin
      if (w_accept) begin
        r_data   <= s_axis.tdata;
        r_last   <= s_axis.tlast;
        r_nbeats <= w_nbeats_in;
        r_k      <= '0;
      end else if (w_m_hs && !w_last_beat) begin
        r_k <= r_k + BW'(1);
      end
      if (w_m_hs && w_last_beat) r_items <= r_items + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// Randomised and directed bench for cms_axis_downsizer; a queue of expected beats
// built from each accepted item is checked against every observed cycle.
module tb_cms_axis_downsizer;
  localparam int IN_W  = 256;
  localparam int OUT_W = 64;
  localparam int CNT_W = 4;
  localparam int RATIO = IN_W / OUT_W;
  localparam int BW    = $clog2(RATIO) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BW-1:0]    beats_per_item;
  logic [CNT_W-1:0] items_sent;
  logic             busy;

  cms_axis_downsizer_if #(.W(IN_W))  s_if ();
  cms_axis_downsizer_if #(.W(OUT_W)) m_if ();

  cms_axis_downsizer #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .beats_per_item(beats_per_item),
    .items_sent    (items_sent),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    logic             fin;
  } beat_t;

  beat_t            exp_q[$];
  logic [CNT_W-1:0] exp_items = '0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               mr_mode = 0;
  int               items_done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic next_mr();
    case (mr_mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return ($urandom % 3) != 0;
    endcase
  endfunction

  // Expected beats of an item, derived directly from the slicing and clamping rules.
  task automatic model_push(input logic [IN_W-1:0] d, input logic l, input logic [BW-1:0] bpi);
    int    n;
    beat_t b;
    n = (bpi == 0 || bpi > RATIO) ? RATIO : int'(bpi);
    for (int i = 0; i < n; i++) begin
      b.data = OUT_W'(d >> (i * OUT_W));
      b.last = l && (i == n - 1);
      b.fin  = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic cycle(input logic sv, input logic [IN_W-1:0] sd, input logic sl,
                       input logic [BW-1:0] bpi, input logic mr, output logic acc);
    beat_t b;
    @(negedge clk);
    s_if.tvalid    = sv;
    s_if.tdata     = sd;
    s_if.tlast     = sl;
    beats_per_item = bpi;
    m_if.tready    = mr;
    #1;
    chk("m_tvalid", 64'(m_if.tvalid), 64'(exp_q.size() > 0));
    chk("busy", 64'(busy), 64'(exp_q.size() > 0));
    chk("s_tready", 64'(s_if.tready), 64'(exp_q.size() == 0 || (exp_q.size() == 1 && mr)));
    chk("items_sent", 64'(items_sent), 64'(exp_items));
    if (m_if.tvalid && exp_q.size() > 0) begin
      chk("m_tdata", m_if.tdata, exp_q[0].data);
      chk("m_tlast", 64'(m_if.tlast), 64'(exp_q[0].last));
    end
    if (m_if.tvalid && mr && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      if (b.fin) begin
        exp_items++;
        items_done++;
        $display("item %0d done: last_beat=%h tlast=%0b items_sent_next=%0d",
                 items_done, b.data, b.last, exp_items);
      end
    end
    acc = sv && s_if.tready;
    if (acc) model_push(sd, sl, bpi);
    cyc++;
  endtask

  task automatic send_item(input logic [IN_W-1:0] d, input logic l, input logic [BW-1:0] bpi);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) cycle(1'b1, d, l, bpi, next_mr(), acc);
    if (!acc) chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int t = 0; t < n; t++) cycle(1'b0, '0, 1'b0, '0, next_mr(), acc);
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) cycle(1'b0, '0, 1'b0, '0, next_mr(), acc);
    if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    idle(1);
  endtask

  function automatic logic [IN_W-1:0] rand_data();
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [IN_W-1:0] pat;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1; beats_per_item = '0;

    // Reset state while held
    #12;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tdata", m_if.tdata, 64'd0);
    chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_items", 64'(items_sent), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    @(posedge clk); #2; rst_n = 1'b1;

    // 1: single item, beats_per_item=0 -> all four words
    pat = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    mr_mode = 0;
    send_item(pat, 1'b1, 3'd0);
    drain();
    chk("t1_items", 64'(items_sent), 64'd1);

    // 2: back-to-back items, no bubble
    send_item(rand_data(), 1'b1, 3'd4);
    send_item(rand_data(), 1'b0, 3'd4);
    drain();
    chk("t2_items", 64'(items_sent), 64'd3);

    // 3: stalling downstream
    mr_mode = 1;
    send_item(rand_data(), 1'b1, 3'd4);
    send_item(rand_data(), 1'b1, 3'd3);
    drain();

    // 4: trimmed and clamped items, tlast low
    mr_mode = 0;
    send_item(rand_data(), 1'b0, 3'd2);
    send_item(rand_data(), 1'b0, 3'd7);
    drain();

    // 5: asynchronous reset mid-item, after beat 2
    send_item(rand_data(), 1'b1, 3'd4);
    idle(2);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("arst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_items", 64'(items_sent), 64'd0);
    chk("arst_s_tready", 64'(s_if.tready), 64'd1);
    exp_q.delete();
    exp_items = '0;
    @(posedge clk); #2; rst_n = 1'b1;
    idle(4);

    // 6: counter wrap at 2^CNT_W
    for (int i = 0; i < 15; i++) send_item(rand_data(), 1'(i & 1), 3'd1);
    drain();
    chk("t6_pre_wrap", 64'(items_sent), 64'd15);
    send_item(rand_data(), 1'b1, 3'd1);
    drain();
    chk("t6_wrap", 64'(items_sent), 64'd0);

    // Random traffic with random back-pressure and gaps
    mr_mode = 2;
    for (int i = 0; i < 120; i++) begin
      idle($urandom_range(0, 2));
      send_item(rand_data(), 1'($urandom), BW'($urandom_range(0, 7)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
